// File: rtl/shift_sequencer.sv
// shift_sequencer: iterative log-stage shifter (SLL/SRL/SRA/ROL) with valid/ready handshakes
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_x/in_shamt/in_op request side;
//   out_valid/out_ready/out_z result side; busy high while a request is in flight.
// Optional feature macro: SHIFT_SEQ_EARLY_EXIT_EN (leave SHIFT once no higher shamt bits remain).
module shift_sequencer #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_z,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [SHAMT_W-1:0] LAST = SHAMT_W'(SHAMT_W - 1);
  state_t               r_state, w_next;
  logic [SHAMT_W-1:0]   r_idx, r_sh;
  logic [1:0]           r_op;
  logic [WIDTH-1:0]     r_acc, r_z, w_step, w_acc_nxt;
  logic [2*WIDTH-1:0]   w_dbl;
  logic [SHAMT_W:0]     w_amt;
  logic                 w_last;
  assign w_amt = (SHAMT_W + 1)'(1) << r_idx;
  // rotate: upper half of the doubled word shifted left
  assign w_dbl = {r_acc, r_acc} << w_amt;
  always_comb
    w_step = r_op == 2'b00 ? r_acc << w_amt :
             r_op == 2'b01 ? r_acc >> w_amt :
             r_op == 2'b10 ? $unsigned($signed(r_acc) >>> w_amt) :
                             w_dbl[2*WIDTH-1:WIDTH];
  assign w_acc_nxt = r_sh[r_idx] ? w_step : r_acc;
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
  // nothing above idx left to apply; also true at the last stage
  assign w_last = (r_sh >> r_idx) <= SHAMT_W'(1);
`else
  assign w_last = r_idx == LAST;
`endif
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  always_comb
    w_next = r_state == IDLE  ? (in_valid  ? SHIFT : IDLE) :
             r_state == SHIFT ? (w_last    ? DONE  : SHIFT) :
                                (out_ready ? IDLE  : DONE);
  always_ff @(posedge clk)
    if (rst) begin
      r_idx <= '0;
      r_sh  <= '0;
      r_op  <= '0;
      r_acc <= '0;
      r_z   <= '0;
    end else if (r_state == IDLE && in_valid) begin
      r_acc <= in_x;
      r_sh  <= in_shamt;
      r_op  <= in_op;
      r_idx <= '0;
    end else if (r_state == SHIFT) begin
      r_acc <= w_acc_nxt;
      r_idx <= r_idx + SHAMT_W'(1);
      if (w_last) r_z <= w_acc_nxt;
    end
  always_comb begin
    in_ready  = r_state == IDLE && !rst;
    out_valid = r_state == DONE;
    busy      = r_state != IDLE;
  end
  assign out_z = r_z;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: randomized and directed checks of shift_sequencer against a behavioural model
module tb_shift_sequencer;
  logic        clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic        in_ready, out_valid, busy;
  logic [31:0] in_x = 0, out_z;
  logic [4:0]  in_shamt = 0;
  logic [1:0]  in_op = 0;
  int          total = 0, bad = 0;
  always #5 clk = ~clk;
  shift_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .in_shamt(in_shamt), .in_op(in_op), .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .busy(busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ref_shift(input logic [31:0] x, input int s, input logic [1:0] op);
    logic [63:0] d;
    d = {x, x} << s;
    case (op)
      2'd0:    return x << s;
      2'd1:    return x >> s;
      2'd2:    return 32'($signed(x) >>> s);
      default: return d[63:32];
    endcase
  endfunction
  function automatic int ref_lat(input int s);
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
    int h = 0;
    for (int i = 0; i < 5; i++) if (s[i]) h = i;
    return h + 1;
`else
    return 5;
`endif
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick;
      n++;
    end
    check({tag, ":ready"}, 32'(in_ready), 32'd1);
  endtask
  task automatic run(input logic [31:0] x, input int s, input logic [1:0] op, input int hold, input string tag);
    logic [31:0] exp;
    int lat;
    exp = ref_shift(x, s, op);
    wait_ready(tag);
    in_valid = 1; in_x = x; in_shamt = s[4:0]; in_op = op;
    tick;
    in_valid = 0; in_x = $urandom; in_shamt = 5'($urandom); in_op = 2'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      out_ready = 1'($urandom);
      tick;
      lat++;
    end
    out_ready = 0;
    check({tag, ":lat"}, 32'(lat), 32'(ref_lat(s)));
    check({tag, ":z"}, out_z, exp);
    check({tag, ":busy"}, 32'(busy), 32'd1);
    check({tag, ":rdy_lo"}, 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      in_x = $urandom;
      tick;
      check({tag, ":hold_z"}, out_z, exp);
      check({tag, ":hold_v"}, 32'(out_valid), 32'd1);
      check({tag, ":hold_rdy"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1;
    tick;
    out_ready = 0;
    check({tag, ":v_lo"}, 32'(out_valid), 32'd0);
    check({tag, ":rdy_hi"}, 32'(in_ready), 32'd1);
    check({tag, ":z_keep"}, out_z, exp);
  endtask
  initial begin
    int seen;
    #1;
    rst = 1;
    repeat (3) begin
      tick;
      check("rst_rdy", 32'(in_ready), 32'd0);
    end
    check("rst_v", 32'(out_valid), 32'd0);
    check("rst_z", out_z, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 0;
    tick;
    check("post_rst_rdy", 32'(in_ready), 32'd1);
    run(32'h0000_0001, 31, 2'd0, 0, "sll31");
    check("sll31_const", out_z, 32'h8000_0000);
    run(32'h8000_00F0, 4, 2'd2, 1, "sra4");
    check("sra4_const", out_z, 32'hF800_000F);
    run(32'h8000_00F0, 4, 2'd1, 0, "srl4");
    check("srl4_const", out_z, 32'h0800_000F);
    run(32'h8000_0001, 1, 2'd3, 10, "rol1");
    check("rol1_const", out_z, 32'h0000_0003);
    run(32'hDEAD_BEEF, 0, 2'd3, 0, "rol0");
    run(32'h8000_0000, 31, 2'd2, 0, "sra31");
    check("sra31_const", out_z, 32'hFFFF_FFFF);
    wait_ready("abort");
    in_valid = 1; in_x = 32'hFFFF_FFFF; in_shamt = 5'd8; in_op = 2'd0;
    tick;
    in_valid = 0;
    tick;
    rst = 1;
    tick;
    rst = 0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_v", 32'(out_valid), 32'd0);
    check("abort_z", out_z, 32'd0);
    seen = 0;
    repeat (8) begin
      tick;
      if (out_valid) seen++;
    end
    check("abort_no_v", 32'(seen), 32'd0);
    run(32'h0000_0100, 8, 2'd1, 0, "after_abort");
    check("after_abort_const", out_z, 32'h0000_0001);
    run(32'h1234_5678, 0, 2'd0, 0, "ee0");
    run(32'h1234_5678, 2, 2'd0, 0, "ee2");
    run(32'h1234_5678, 16, 2'd0, 0, "ee16");
    for (int k = 0; k < 40; k++)
      run($urandom, int'($urandom_range(0, 31)), 2'($urandom), int'($urandom_range(0, 3)), "rand");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
